// File: rtl/ysyx_23060077_id_alu_issue_pkg.sv
// Shared decode constants for the ID->EX ALU issue slice: widths, ALU opcodes,
// RV32I major opcodes and the funct3-to-ALU map shared by OP and OP-IMM.
package ysyx_23060077_id_alu_issue_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int ALU_OPT_WIDTH = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_SUBU = 4'd10
    } alu_opt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    // alt picks SUB over ADD and SRA over SRL; other funct3 values ignore it
    function automatic alu_opt_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060077_id_alu_issue_if.sv
// IF->ID input channel and ID->EX output channel; slave is the issue block,
// master is the upstream fetch plus downstream EX side.
interface ysyx_23060077_id_alu_issue_if #(
    parameter int DATA_WIDTH    = ysyx_23060077_id_alu_issue_pkg::DATA_WIDTH,
    parameter int ALU_OPT_WIDTH = ysyx_23060077_id_alu_issue_pkg::ALU_OPT_WIDTH
);
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_inst;
    logic [DATA_WIDTH-1:0]    in_pc;
    logic [DATA_WIDTH-1:0]    in_rs1_data;
    logic [DATA_WIDTH-1:0]    in_rs2_data;

    logic                     out_valid;
    logic                     out_ready;
    logic [ALU_OPT_WIDTH-1:0] out_alu_opt;
    logic [DATA_WIDTH-1:0]    out_alu_a;
    logic [DATA_WIDTH-1:0]    out_alu_b;
    logic [4:0]               out_rd;
    logic                     out_rd_wen;
    logic [DATA_WIDTH-1:0]    out_pc;
    logic                     out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, out_alu_opt, out_alu_a, out_alu_b,
               out_rd, out_rd_wen, out_pc, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, out_alu_opt, out_alu_a, out_alu_b,
               out_rd, out_rd_wen, out_pc, out_illegal
    );
endinterface

// File: rtl/ysyx_23060077_id_alu_issue_imm_gen.sv
// RV32I immediate extraction (I/S/B/U/J), sign-extended to DATA_WIDTH.
// Purely combinational; the opcode field inst[6:0] is not needed here.
module ysyx_23060077_id_imm_gen
    import ysyx_23060077_id_alu_issue_pkg::*;
#(
    parameter int DATA_WIDTH = ysyx_23060077_id_alu_issue_pkg::DATA_WIDTH
) (
    input  logic [31:7]           inst,
    input  imm_sel_e              sel,
    output logic [DATA_WIDTH-1:0] imm
);
    logic [31:0] raw;

    always_comb begin
        raw = '0;
        case (sel)
            IMM_I:   raw = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   raw = {inst[31:12], 12'b0};
            IMM_J:   raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: raw = '0;
        endcase
    end

    assign imm = DATA_WIDTH'($signed(raw));

endmodule

// File: rtl/ysyx_23060077_id_alu_issue.sv
// Decode one RV32I instruction into ALU opcode/operands; 1-cycle latency through a 2-entry
// skid buffer, in_ready is a pure register (!skid). Optional YSYX_23060077_ILLEGAL_INST_EN.
module ysyx_23060077_id_alu_issue #(
    parameter int DATA_WIDTH    = ysyx_23060077_id_alu_issue_pkg::DATA_WIDTH,
    parameter int ALU_OPT_WIDTH = ysyx_23060077_id_alu_issue_pkg::ALU_OPT_WIDTH
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic                         flush,
    ysyx_23060077_id_alu_issue_if.slave  io
);
    import ysyx_23060077_id_alu_issue_pkg::*;

    typedef struct packed {
        logic [ALU_OPT_WIDTH-1:0] opt;
        logic [DATA_WIDTH-1:0]    a;
        logic [DATA_WIDTH-1:0]    b;
        logic [4:0]               rd;
        logic                     rd_wen;
        logic [DATA_WIDTH-1:0]    pc;
        logic                     illegal;
    } entry_t;

    logic [6:0]            opc;
    logic [2:0]            f3;
    logic [4:0]            rd;
    imm_sel_e              imm_sel;
    logic [DATA_WIDTH-1:0] imm;
    logic                  chk_ill;
    entry_t                dec;

    assign opc = io.in_inst[6:0];
    assign f3  = io.in_inst[14:12];
    assign rd  = io.in_inst[11:7];

    always_comb begin
        imm_sel = IMM_I;
        case (opc)
            OPC_STORE:           imm_sel = IMM_S;
            OPC_LUI, OPC_AUIPC:  imm_sel = IMM_U;
            default:             imm_sel = IMM_I;
        endcase
    end

    ysyx_23060077_id_imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .inst (io.in_inst[31:7]),
        .sel  (imm_sel),
        .imm  (imm)
    );

`ifdef YSYX_23060077_ILLEGAL_INST_EN
    logic [6:0] f7;
    assign f7 = io.in_inst[31:25];

    always_comb begin
        chk_ill = 1'b0;
        case (opc)
            OPC_OP:     chk_ill = !(f7 == 7'h00 ||
                                    (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            OPC_OP_IMM: chk_ill = (f3 == 3'b001 && f7 != 7'h00) ||
                                  (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
            OPC_LOAD:   chk_ill = f3 inside {3'b011, 3'b110, 3'b111};
            OPC_STORE:  chk_ill = f3[2] | (f3[1] & f3[0]);
            OPC_BRANCH: chk_ill = (f3[2:1] == 2'b01);
            default:    chk_ill = 1'b0;
        endcase
    end
`else
    assign chk_ill = 1'b0;
`endif

    always_comb begin
        dec         = '0;
        dec.rd      = rd;
        dec.pc      = io.in_pc;
        dec.opt     = ALU_OPT_WIDTH'(ALU_ADD);
        case (opc)
            OPC_OP: begin
                dec.a      = io.in_rs1_data;
                dec.b      = io.in_rs2_data;
                dec.opt    = ALU_OPT_WIDTH'(alu_from_f3(f3, io.in_inst[30]));
                dec.rd_wen = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.a      = io.in_rs1_data;
                // shifts carry a 5-bit zero-extended shamt instead of the immediate
                dec.b      = (f3 == 3'b001 || f3 == 3'b101) ? DATA_WIDTH'(io.in_inst[24:20]) : imm;
                dec.opt    = ALU_OPT_WIDTH'(alu_from_f3(f3, (f3 == 3'b101) && io.in_inst[30]));
                dec.rd_wen = 1'b1;
            end
            OPC_LUI: begin
                dec.b      = imm;
                dec.rd_wen = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a      = io.in_pc;
                dec.b      = imm;
                dec.rd_wen = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec.a      = io.in_pc;
                dec.b      = DATA_WIDTH'(4);
                dec.rd_wen = 1'b1;
            end
            OPC_LOAD: begin
                dec.a      = io.in_rs1_data;
                dec.b      = imm;
                dec.rd_wen = 1'b1;
            end
            OPC_STORE: begin
                dec.a      = io.in_rs1_data;
                dec.b      = imm;
            end
            OPC_BRANCH: begin
                dec.a      = io.in_rs1_data;
                dec.b      = io.in_rs2_data;
                dec.opt    = ALU_OPT_WIDTH'(f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB);
            end
            default: dec.illegal = 1'b1;
        endcase
        if (chk_ill)
            dec.illegal = 1'b1;
        if (dec.illegal) begin
            dec.opt    = ALU_OPT_WIDTH'(ALU_ADD);
            dec.a      = '0;
            dec.b      = '0;
            dec.rd_wen = 1'b0;
        end
        if (rd == 5'd0)
            dec.rd_wen = 1'b0;
    end

    logic   main_vld;
    logic   skid_vld;
    entry_t main_q;
    entry_t skid_q;
    logic   accept;

    assign accept = io.in_valid && !skid_vld;

    // skid only fills while main is held, so !main_vld implies !skid_vld
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || io.out_ready) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                main_vld <= accept;
                if (accept)
                    main_q <= dec;
            end
        end else if (accept) begin
            skid_q   <= dec;
            skid_vld <= 1'b1;
        end
    end

    assign io.in_ready    = !skid_vld;
    assign io.out_valid   = main_vld;
    assign io.out_alu_opt = main_q.opt;
    assign io.out_alu_a   = main_q.a;
    assign io.out_alu_b   = main_q.b;
    assign io.out_rd      = main_q.rd;
    assign io.out_rd_wen  = main_q.rd_wen;
    assign io.out_pc      = main_q.pc;
    assign io.out_illegal = main_q.illegal;

endmodule

// File: doc/ysyx_23060077_id_alu_issue.md
Name: ysyx_23060077_id_alu_issue

Overview:
- Decode-side producer for the EX-stage ALU. It takes one fetched RV32I instruction per handshake, together with the PC and the register-file read data.
- It decodes the instruction into the ALU opcode and the A/B operands, plus writeback control.
- It delivers the result to EX through a registered valid/ready interface with a 2-entry skid buffer. This gives full throughput without a combinational ready path from EX back to IF.

Parameters:
- DATA_WIDTH, 32, operand/PC width.
- ALU_OPT_WIDTH, 4, ALU opcode width.

Ports:
- clock  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous kill of all buffered entries (redirect).
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  DATA_WIDTH  instruction PC.
- in_rs1_data  in  DATA_WIDTH  GPR[rs1].
- in_rs2_data  in  DATA_WIDTH  GPR[rs2].
- out_valid  out  1  entry presented to EX.
- out_ready  in  1  EX accepts.
- out_alu_opt  out  ALU_OPT_WIDTH  ALU opcode.
- out_alu_a  out  DATA_WIDTH  ALU operand A.
- out_alu_b  out  DATA_WIDTH  ALU operand B.
- out_rd  out  5  destination register.
- out_rd_wen  out  1  writeback enable; forced 0 when rd==0.
- out_pc  out  DATA_WIDTH  PC passthrough.
- out_illegal  out  1  undecodable instruction (see Optional Feature).

Behaviour:
- Reset (rst_n low, async): both buffer entries invalid; out_valid=0, in_ready=1, all data outputs 0.
- Opcode encoding:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, SUBU=10.
  - Any other value is undefined for EX.
- Decode, combinational before the buffer:
  - OP: A=rs1, B=rs2. The funct3/funct7 map selects the opcode; funct7[5] selects SUB vs ADD and SRA vs SRL.
  - OP-IMM: A=rs1, B=sign-extended I-immediate.
    - Shift forms take shamt = inst[24:20] zero-extended.
    - SRAI is selected by inst[30].
  - LUI: A=0, B=U-immediate, opcode ADD.
  - AUIPC: A=pc, B=U-immediate, opcode ADD.
  - JAL/JALR: A=pc, B=4, opcode ADD (link value).
  - LOAD: A=rs1, B=I-immediate, opcode ADD. STORE: A=rs1, B=S-immediate, opcode ADD. Both have rd_wen=0 for STORE.
  - BRANCH: A=rs1, B=rs2, rd_wen=0.
    - BEQ/BNE use SUB.
    - BLT/BGE use SLT.
    - BLTU/BGEU use SLTU.
  - Any other opcode: opcode ADD, A=B=0, rd_wen=0, illegal=1.
  - All immediates are sign-extended to DATA_WIDTH; all arithmetic is modulo 2^DATA_WIDTH.
- Skid buffer: two entries, main (drives outputs) and skid.
  - Latency: an accepted instruction appears on out_* the next cycle.
  - in_ready = !skid_valid, taken from a register with no combinational path from out_ready.
  - Accept when in_valid && in_ready.
  - Main empty, or main consumed this cycle (out_ready && out_valid): the new entry goes to main, or skid moves to main first if skid is valid.
  - Main held (out_valid && !out_ready) and an accept occurs: the entry goes to skid.
  - Skid valid and out_ready: skid moves to main; in_ready rises the next cycle.
  - out_* are stable while out_valid && !out_ready.
- flush:
  - Both entries are invalidated next edge, and any accept in the same cycle is discarded.
  - flush has priority over all handshakes.
  - in_ready=1 the following cycle.
- Mid-operation reset: entries drop immediately and asynchronously; no partial entry survives.

Optional Feature:
- Macro YSYX_23060077_ILLEGAL_INST_EN.
- Defined:
  - Full illegal checking: bad funct7 on OP, bad funct3 on BRANCH/LOAD/STORE, and non-zero inst[31:25] on SLLI/SRLI other than 0x20 for SRAI.
  - out_illegal is registered with the entry.
- Undefined:
  - Only the unknown-opcode case sets illegal.
  - Unchecked fields decode by funct3 alone.

Decomposition:
- Shared define header holds the ALU opcode constants, ALU_OPT_WIDTH, DATA_WIDTH, and the RV32I major-opcode constants.
- One sub-module, ysyx_23060077_id_imm_gen: combinational I/S/B/U/J immediate extraction.
- The skid buffer stays inline.

Test Plan:
- Reset and single op:
  - Release rst_n; send ADDI x5,x1,-1 with rs1=0x10 and out_ready=1.
  - Next cycle: out_valid=1, opt=ADD, a=0x10, b=0xFFFFFFFF, rd=5, rd_wen=1.
- Decode sweep:
  - SUB -> opt=1. SRAI x3,x3,4 -> opt=7, b=4. AUIPC with pc=0x80000000, imm=0x1 -> a=0x80000000, b=0x1000.
  - BLTU -> opt=4, rd_wen=0. ADD x0 -> rd_wen=0.
- Backpressure:
  - out_ready=0 while streaming 3 instructions.
  - Exactly 2 accepted; in_ready=0 after the second; outputs hold the first.
  - Release out_ready: order is preserved and there are no duplicates.
- Full throughput: with out_ready=1 and in_valid=1 for 100 cycles -> 100 outputs, one per cycle.
- Flush:
  - With both entries full, assert flush with in_valid=1.
  - Next cycle: out_valid=0 and in_ready=1; the flushed instruction never emerges.
- Illegal instructions:
  - inst=0x0000007F -> illegal=1 in both builds.
  - OP with funct7=0x01 -> illegal=1 only with YSYX_23060077_ILLEGAL_INST_EN defined.
